// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: owns the architectural PC and EPC for the multicycle
// datapath. Arbitrates PC-change requests, drives the PC source mux select,
// and sequences exception entry through a vector-read handshake.
module pc_update_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc_req,
  input  logic        branch_req,
  input  logic [1:0]  br_type,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        jump_req,
  input  logic        eret_req,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        vec_valid,
  input  logic [31:0] pc_next,
  output logic [2:0]  pc_sel,
  output logic        pc_write,
  output logic [31:0] pc_q,
  output logic [31:0] epc_q,
  output logic        vec_req,
  output logic [31:0] vec_addr,
  output logic        busy
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] VEC_WAIT = 1'b1;

  localparam logic [2:0] SEL_INC  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_EPC  = 3'd3;
  localparam logic [2:0] SEL_VEC  = 3'd4;

  logic [0:0] state, state_nxt;
  logic [1:0] cause_q;
  logic       br_taken;
  logic       exc_take;

  // Branch condition from ALU flags
  always_comb begin
    br_taken = 1'b0;
    case (br_type)
      2'b00:   br_taken = alu_zero;
      2'b01:   br_taken = ~alu_zero;
      2'b10:   br_taken = alu_neg | alu_zero;
      default: br_taken = ~alu_neg & ~alu_zero;
    endcase
  end

  // Request arbitration and mux select; outputs are held at their reset
  // values while reset_n is low so the async reset is visible immediately
  always_comb begin
    pc_sel    = SEL_INC;
    pc_write  = 1'b0;
    state_nxt = state;
    exc_take  = 1'b0;
    if (reset_n) begin
      if (state == VEC_WAIT) begin
        pc_sel   = SEL_VEC;
        pc_write = vec_valid;
        if (vec_valid) state_nxt = IDLE;
      end else if (exc_req) begin
        exc_take  = 1'b1;
        state_nxt = VEC_WAIT;
      end else if (eret_req) begin
        pc_sel   = SEL_EPC;
        pc_write = 1'b1;
      end else if (jump_req) begin
        pc_sel   = SEL_JMP;
        pc_write = 1'b1;
      end else if (branch_req && br_taken) begin
        pc_sel   = SEL_BR;
        pc_write = 1'b1;
      end else if (inc_req) begin
        pc_write = 1'b1;
      end
    end
  end

  // Vector handshake outputs, driven only while waiting on the vector read
  always_comb begin
    vec_req  = (state == VEC_WAIT);
    busy     = (state == VEC_WAIT);
    vec_addr = '0;
    if (state == VEC_WAIT) begin
      case (cause_q)
        2'b01:   vec_addr = 32'h0000_00FE;
        2'b10:   vec_addr = 32'h0000_00FF;
        default: vec_addr = 32'h0000_00FD;
      endcase
    end
  end

  // State, PC, EPC and latched cause registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cause_q <= 2'b00;
      pc_q    <= '0;
      epc_q   <= '0;
    end else begin
      state <= state_nxt;
      if (pc_write) pc_q <= pc_next;
      if (exc_take) begin
        epc_q   <= exc_pc;
        cause_q <= exc_cause;
      end
    end
  end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Testbench for pc_update_ctrl: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model of PC/EPC behaviour.
module tb_pc_update_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inc_req, branch_req, alu_zero, alu_neg, jump_req, eret_req, exc_req;
  logic [1:0]  br_type, exc_cause;
  logic [31:0] exc_pc, pc_next;
  logic        vec_valid;
  logic [2:0]  pc_sel;
  logic        pc_write, vec_req, busy;
  logic [31:0] pc_q, epc_q, vec_addr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  bit          m_busy;

  always #5 clk = ~clk;

  pc_update_ctrl dut (
    .clk(clk), .reset_n(reset_n), .inc_req(inc_req), .branch_req(branch_req),
    .br_type(br_type), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .jump_req(jump_req), .eret_req(eret_req), .exc_req(exc_req),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .vec_valid(vec_valid),
    .pc_next(pc_next), .pc_sel(pc_sel), .pc_write(pc_write), .pc_q(pc_q),
    .epc_q(epc_q), .vec_req(vec_req), .vec_addr(vec_addr), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vec_of(input logic [1:0] c);
    if (c == 2'd1) return 32'hFE;
    if (c == 2'd2) return 32'hFF;
    return 32'hFD;
  endfunction

  function automatic bit taken_of(input logic [1:0] t, input bit z, input bit n);
    bit lt_or_eq = n || z;
    case (t)
      2'd0: return z;
      2'd1: return !z;
      2'd2: return lt_or_eq;
      default: return !lt_or_eq;
    endcase
  endfunction

  // One clock cycle: drive request set, check combinational outputs, then
  // check registered state after the edge.
  task automatic cycle(input bit inc, input bit br, input logic [1:0] bt,
                       input bit z, input bit n, input bit j, input bit e,
                       input bit x, input logic [1:0] cs, input logic [31:0] xpc,
                       input bit vv, input logic [31:0] tgt);
    logic [2:0]  esel;
    bit          ewr;
    logic [31:0] src;
    @(negedge clk);
    inc_req = inc; branch_req = br; br_type = bt; alu_zero = z; alu_neg = n;
    jump_req = j; eret_req = e; exc_req = x; exc_cause = cs; exc_pc = xpc;
    vec_valid = vv;
    if (m_busy)                          begin esel = 3'd4; ewr = vv; end
    else if (x)                          begin esel = 3'd0; ewr = 1'b0; end
    else if (e)                          begin esel = 3'd3; ewr = 1'b1; end
    else if (j)                          begin esel = 3'd2; ewr = 1'b1; end
    else if (br && taken_of(bt, z, n))   begin esel = 3'd1; ewr = 1'b1; end
    else                                 begin esel = 3'd0; ewr = inc; end
    // datapath mux model
    case (esel)
      3'd0:    src = m_pc + 32'd4;
      3'd3:    src = m_epc;
      default: src = tgt;
    endcase
    pc_next = src;
    #1;
    chk("pc_sel",   {29'd0, pc_sel}, {29'd0, esel});
    chk("pc_write", {31'd0, pc_write}, {31'd0, ewr});
    chk("vec_req",  {31'd0, vec_req}, {31'd0, m_busy});
    chk("busy",     {31'd0, busy}, {31'd0, m_busy});
    chk("vec_addr", vec_addr, m_busy ? vec_of(m_cause) : 32'd0);
    @(posedge clk);
    if (ewr) m_pc = src;
    if (m_busy) begin
      if (vv) m_busy = 0;
    end else if (x) begin
      m_epc = xpc; m_cause = cs; m_busy = 1;
    end
    #1;
    chk("pc_q",  pc_q,  m_pc);
    chk("epc_q", epc_q, m_epc);
  endtask

  task automatic idle_inputs();
    inc_req = 0; branch_req = 0; br_type = 0; alu_zero = 0; alu_neg = 0;
    jump_req = 0; eret_req = 0; exc_req = 0; exc_cause = 0; exc_pc = 0;
    vec_valid = 0; pc_next = 0;
  endtask

  // Async reset asserted mid-cycle with requests pending; outputs must clear
  // immediately and stay cleared until release.
  task automatic do_reset();
    @(negedge clk);
    inc_req = 1; jump_req = 1; vec_valid = 1; pc_next = 32'h1234_5678;
    #2 reset_n = 0;
    #1;
    chk("rst_pc_q", pc_q, 32'd0);
    chk("rst_epc_q", epc_q, 32'd0);
    chk("rst_pc_sel", {29'd0, pc_sel}, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst_vec_req", {31'd0, vec_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vec_addr", vec_addr, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_pc_q", pc_q, 32'd0);
    @(negedge clk);
    idle_inputs();
    reset_n = 1;
    m_pc = 0; m_epc = 0; m_cause = 0; m_busy = 0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    m_pc = 0; m_epc = 0; m_cause = 0; m_busy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;

    // some activity, then reset mid-run
    cycle(0,0,0,0,0,1,0,0,0,0,0,32'h500);
    cycle(1,0,0,0,0,0,0,0,0,0,0,0);
    do_reset();

    // sequential increments 0 -> 4 -> 8 -> C
    repeat (3) cycle(1,0,0,0,0,0,0,0,0,0,0,0);
    chk("inc_seq_pc", pc_q, 32'hC);

    // branches from pc=0x40 to 0x80: each type taken, then not taken
    cycle(0,0,0,0,0,1,0,0,0,0,0,32'h40);
    cycle(0,1,2'd0,1,0,0,0,0,0,0,0,32'h80); chk("beq_t", pc_q, 32'h80);
    cycle(0,0,0,0,0,1,0,0,0,0,0,32'h40);
    cycle(0,1,2'd0,0,0,0,0,0,0,0,0,32'h80); chk("beq_nt", pc_q, 32'h40);
    cycle(0,1,2'd1,0,0,0,0,0,0,0,0,32'h80); chk("bne_t", pc_q, 32'h80);
    cycle(0,0,0,0,0,1,0,0,0,0,0,32'h40);
    cycle(0,1,2'd1,1,0,0,0,0,0,0,0,32'h80); chk("bne_nt", pc_q, 32'h40);
    cycle(0,1,2'd2,0,1,0,0,0,0,0,0,32'h80); chk("ble_t", pc_q, 32'h80);
    cycle(0,0,0,0,0,1,0,0,0,0,0,32'h40);
    cycle(0,1,2'd2,0,0,0,0,0,0,0,0,32'h80); chk("ble_nt", pc_q, 32'h40);
    cycle(0,1,2'd3,0,0,0,0,0,0,0,0,32'h80); chk("bgt_t", pc_q, 32'h80);
    cycle(0,0,0,0,0,1,0,0,0,0,0,32'h40);
    cycle(0,1,2'd3,0,1,0,0,0,0,0,0,32'h80); chk("bgt_nt", pc_q, 32'h40);

    // set EPC=0x100 via a short exception (cause 0), then eret wins priority
    cycle(0,0,0,0,0,0,0,1,2'd0,32'h100,0,0);
    cycle(0,0,0,0,0,0,0,0,0,0,1,32'h300);
    chk("exc_min_pc", pc_q, 32'h300);
    cycle(1,0,0,0,0,1,1,0,0,0,0,32'h444);
    chk("eret_prio_pc", pc_q, 32'h100);

    // cause=01, 3 wait cycles with jump and a second exc ignored
    cycle(0,0,0,0,0,0,0,1,2'd1,32'h24,0,0);
    chk("epc_saved", epc_q, 32'h24);
    cycle(0,0,0,0,0,1,0,0,0,0,0,32'h777);
    cycle(0,0,0,0,0,0,0,1,2'd2,32'h99,0,0);
    cycle(1,0,0,0,0,0,1,0,0,0,0,0);
    chk("epc_kept", epc_q, 32'h24);
    cycle(0,0,0,0,0,0,0,0,0,0,1,32'h200);
    chk("vec_pc", pc_q, 32'h200);
    cycle(0,0,0,0,0,0,0,0,0,0,0,0);

    // cause=11 -> 0xFD
    cycle(0,0,0,0,0,0,0,1,2'd3,32'h30,0,0);
    chk("vec_fd", vec_addr, 32'hFD);
    cycle(0,0,0,0,0,0,0,0,0,0,1,32'h210);

    // cause=10 -> 0xFF, then reset aborts the sequence
    cycle(0,0,0,0,0,0,0,1,2'd2,32'h34,0,0);
    chk("vec_ff", vec_addr, 32'hFF);
    cycle(0,0,0,0,0,0,0,0,0,0,0,0);
    do_reset();
    cycle(0,0,0,0,0,0,0,0,0,0,1,32'h999);

    // wrap-around from 0xFFFF_FFFC: mux yields 0, loaded verbatim
    cycle(0,0,0,0,0,1,0,0,0,0,0,32'hFFFF_FFFC);
    cycle(1,0,0,0,0,0,0,0,0,0,0,0);
    chk("wrap_pc", pc_q, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle($urandom_range(0,1), $urandom_range(0,1), 2'($urandom_range(0,3)),
            $urandom_range(0,1), $urandom_range(0,1),
            $urandom_range(0,3) == 0, $urandom_range(0,5) == 0,
            $urandom_range(0,9) == 0, 2'($urandom_range(0,3)),
            $urandom & 32'hFFFF_FFFC, $urandom_range(0,2) == 0,
            $urandom & 32'hFFFF_FFFC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_update_ctrl.md
# pc_update_ctrl

Program-counter owner for the multicycle datapath. Arbitrates the per-cycle PC-change requests from the control unit, drives the 3-bit select of the PC source multiplexer, captures the multiplexer's output into the architectural PC, and holds EPC. It also sequences exception entry: it saves EPC, fetches the handler address through a request/valid handshake to the vector read port, and loads that address into PC.

## Interface
- No parameters. Widths fixed at 32-bit data, 3-bit select.
- clk  in  1  rising-edge clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- inc_req  in  1  sequential update; PC <= PC+4 (source 0).
- branch_req  in  1  conditional branch; target on source 1.
- br_type  in  2  00 beq (zero), 01 bne (!zero), 10 ble (neg|zero), 11 bgt (!neg&!zero).
- alu_zero, alu_neg  in  1 each  ALU flags evaluated with branch_req.
- jump_req  in  1  unconditional jump/jr; target on source 2.
- eret_req  in  1  return from exception; PC <= EPC (source 3).
- exc_req  in  1  exception entry.
- exc_cause  in  2  00 opcode, 01 overflow, 10 div-by-zero, 11 reserved (treated as opcode).
- exc_pc  in  32  faulting-instruction address, saved to EPC.
- vec_valid  in  1  vector read data valid on pc_next (source 4).
- pc_next  in  32  PC source multiplexer output.
- pc_sel  out  3  multiplexer select: 0 PC+4, 1 branch target, 2 jump target, 3 EPC, 4 vector.
- pc_write  out  1  PC loaded at the next edge (observability).
- pc_q  out  32  architectural PC.
- epc_q  out  32  EPC; also feeds multiplexer source 3.
- vec_req  out  1  vector read request.
- vec_addr  out  32  vector address: opcode 0x0000_00FD, overflow 0x0000_00FE, div0 0x0000_00FF.
- busy  out  1  exception sequence in progress.

## Operation
- FSM states: IDLE, VEC_WAIT.
- IDLE priority: exc_req > eret_req > jump_req > taken branch > inc_req.
  - exc_req: EPC <= exc_pc; latch cause; go to VEC_WAIT; no PC write.
  - eret: pc_sel=3, pc_write=1.
  - jump: pc_sel=2, pc_write=1.
  - branch taken per br_type: pc_sel=1, pc_write=1. Not taken: no write; pc_sel=0.
  - inc: pc_sel=0, pc_write=1.
  - No request: pc_sel=0, pc_write=0.
- VEC_WAIT: vec_req=1, busy=1, vec_addr from the latched cause, pc_sel=4.
  - vec_valid=1: pc_write=1; PC <= pc_next; back to IDLE.
  - All other requests, including a new exc_req, are ignored. EPC is not overwritten.
- pc_sel and pc_write are combinational from state and inputs. pc_q and epc_q are registered; PC loads pc_next only when pc_write=1.
- In IDLE: vec_addr = 0, vec_req = 0, busy = 0.

## Timing
- Reset (async assert, any state): pc_q=0, epc_q=0, state=IDLE, latched cause=00, pc_sel=0, pc_write=0, vec_req=0, busy=0, vec_addr=0.
- Reset release takes effect at the first rising edge after reset_n goes high.
- Normal update latency: request in cycle N → pc_q = pc_next sampled at the end of cycle N.
- Exception sequence:
  - Cycle N: exc_req sampled; EPC updates at the end of N.
  - Cycle N+1 onward: vec_req high.
  - First cycle with vec_valid: PC loads; vec_req drops in the following cycle.
  - Minimum entry latency is 2 cycles.
- vec_valid outside VEC_WAIT is ignored.
- Reset asserted during VEC_WAIT aborts the sequence; EPC is cleared.
- Simultaneous requests resolve by priority only; lower-priority requests are dropped, not queued.
- PC arithmetic and wrap-around belong to the datapath. pc_next=0xFFFF_FFFC+4 wrapping to 0 is loaded verbatim.

## Test plan
- Reset mid-run, then inc_req for 3 cycles with the mux model producing PC+4 → pc_q 0→4→8→0xC; pc_sel=0 each cycle.
- pc_q=0x40, branch_req, br_type=00, alu_zero=1, target 0x80 → pc_sel=1, pc_q=0x80. Same with alu_zero=0 → pc_q stays 0x40, pc_write=0. Repeat for bne, ble (neg=1), bgt (neg=0, zero=0).
- jump_req, eret_req, and inc_req in the same cycle with EPC=0x100 → eret wins, pc_sel=3, pc_q=0x100.
- exc_req with cause=01 and exc_pc=0x24; vec_valid held low 3 cycles, then high with pc_next=0x200 → epc_q=0x24 after 1 edge; vec_addr=0xFE with vec_req high 4 cycles; jump_req during the wait ignored; pc_q=0x200; busy low afterward.
- A second exc_req (exc_pc=0x99) during VEC_WAIT → epc_q stays 0x24. reset_n pulsed low in VEC_WAIT → all outputs at reset values immediately, state IDLE.
- cause=11 → vec_addr=0xFD. cause=10 → vec_addr=0xFF.
